reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V cores: NRD async read ports, NWR write ports.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_init_seq.sv | 53 +++++
 rtl/reg_file_mp.sv | 94 +++++++++
 tb/tb_reg_file_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package reg_file_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  function automatic int unsigned rf_aw(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic logic [63:0] rf_init_val(input int unsigned idx, input int unsigned step);
    return 64'(idx) * 64'(step);
  endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Init/clear sequencer: walks every register once after reset or clr, then holds RUN with ready high.
module reg_file_init_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned INIT_STEP = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clr,
  output logic                     o_init_we_c,
  output logic [rf_aw(NREGS)-1:0]  o_init_addr_c,
  output logic [XLEN-1:0]          o_init_data_c,
  output logic                     o_ready
);

  localparam int unsigned AW = rf_aw(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e       r_state;
  logic [AW-1:0]   r_idx;
  logic            r_ready;

  // clr in RUN returns to INIT; clr in INIT restarts the walk from register 0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RF_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == RF_INIT) begin
      if (i_clr) begin
        r_idx <= '0;
      end else if (r_idx == LAST_IDX) begin
        r_state <= RF_RUN;
        r_ready <= 1'b1;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + AW'(1);
      end
    end else if (i_clr) begin
      r_state <= RF_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end
  end

  assign o_init_we_c   = (r_state == RF_INIT);
  assign o_init_addr_c = r_idx;
  assign o_init_data_c = XLEN'(rf_init_val(32'(r_idx), INIT_STEP));
  assign o_ready       = r_ready;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD async read ports, NWR prioritised write ports, sequenced init.
// Define REG_FILE_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned NWR       = 1,
  parameter int unsigned INIT_STEP = 0,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clr,
  input  logic [NWR-1:0]                i_wr_en,
  input  logic [NWR*rf_aw(NREGS)-1:0]   i_waddr,
  input  logic [NWR*XLEN-1:0]           i_wdata,
  input  logic [NRD*rf_aw(NREGS)-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0]           o_rdata_c,
  output logic                          o_ready
);

  localparam int unsigned AW = rf_aw(NREGS);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_init_we;
  logic [AW-1:0]   w_init_addr;
  logic [XLEN-1:0] w_init_data;
  logic            w_ready;
  logic [NWR-1:0]  w_wr_ok;

  reg_file_init_seq #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .INIT_STEP (INIT_STEP)
  ) u_init_seq (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clr         (i_clr),
    .o_init_we_c   (w_init_we),
    .o_init_addr_c (w_init_addr),
    .o_init_data_c (w_init_data),
    .o_ready       (w_ready)
  );

  // Addressable and not the hardwired zero register
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < NWR; p++) begin
      w_wr_ok[p] = w_ready && i_wr_en[p] && addr_ok(i_waddr[p*AW +: AW]);
    end
  end

  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision
  always_ff @(posedge i_clk) begin
    if (w_init_we) begin
      r_mem[w_init_addr] <= w_init_data;
    end
    for (int p = 0; p < NWR; p++) begin
      if (w_wr_ok[p]) begin
        r_mem[i_waddr[p*AW +: AW]] <= i_wdata[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin : p_read
    logic [AW-1:0] w_ra;
    w_ra      = '0;
    o_rdata_c = '0;
    for (int r = 0; r < NRD; r++) begin
      w_ra = i_raddr[r*AW +: AW];
      if (w_ready && addr_ok(w_ra)) begin
        o_rdata_c[r*XLEN +: XLEN] = r_mem[w_ra];
`ifdef REG_FILE_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (w_wr_ok[p] && (i_waddr[p*AW +: AW] == w_ra)) begin
            o_rdata_c[r*XLEN +: XLEN] = i_wdata[p*XLEN +: XLEN];
          end
        end
`else
        o_rdata_c[r*XLEN +: XLEN] = r_mem[w_ra];
`endif
      end
    end
  end

  assign o_ready = w_ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (XLEN=32, NREGS=32, NRD=2, NWR=2, INIT_STEP=10, ZERO_REG=1).
module tb_reg_file_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned STEP  = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clr;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic                 ready;

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .INIT_STEP(STEP), .ZERO_REG(1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_clr(clr), .i_wr_en(wr_en), .i_waddr(waddr),
    .i_wdata(wdata), .i_raddr(raddr), .o_rdata_c(rdata), .o_ready(ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the file is either initialising (counting cycles) or running with a full register image
  logic [31:0] m_mem [NREGS];
  bit          m_run   = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_cnt   = 0;
    end else if (m_valid) begin
      if (m_run) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && waddr[p*AW +: AW] != 0)
            m_mem[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
        end
        if (clr) begin
          m_run = 1'b0;
          m_cnt = 0;
        end
      end else if (clr) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == NREGS) begin
          m_run = 1'b1;
          for (int i = 0; i < NREGS; i++) m_mem[i] = 32'(i * STEP);
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (!m_run || a == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    for (int p = NWR - 1; p >= 0; p--) begin
      if (wr_en[p] && waddr[p*AW +: AW] == a) return wdata[p*XLEN +: XLEN];
    end
`endif
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ready", 32'(ready), 32'(m_run));
      for (int r = 0; r < NRD; r++)
        check($sformatf("model_rdata%0d", r), rdata[r*XLEN +: XLEN], exp_rd(raddr[r*AW +: AW]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]               = 1'b1;
    waddr[p*AW +: AW]      = AW'(a);
    wdata[p*XLEN +: XLEN]  = d;
  endtask

  task automatic rd(input int r, input int a);
    raddr[r*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    wr_en = '0;
    clr   = 1'b0;
  endtask

  // Expects NREGS cycles with ready low, then ready high; optional writes during INIT must be lost
  task automatic wait_ready(input string name, input bit junk);
    for (int i = 0; i < NREGS; i++) begin
      if (junk) wr(0, 7, 32'h9000 + 32'(i));
      @(negedge clk);
      check({name, "_busy"}, 32'(ready), 32'd0);
      if (junk) check({name, "_rd_busy"}, rdata[31:0], 32'd0);
      cyc();
    end
    idle();
    @(negedge clk);
    check({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr_en = '0; waddr = '0; wdata = '0; raddr = '0;
    rd(0, 5); rd(1, 0);
    cyc();
    reset = 1'b0;
    wait_ready("t1", 1'b0);
    check("t1_reg5", rdata[31:0], 32'd50);
    check("t1_reg0", rdata[63:32], 32'd0);
    cyc();

    wr(0, 7, 32'hDEADBEEF); rd(0, 7); rd(1, 7);
    cyc(); idle();
    @(negedge clk);
    check("t2_rd0", rdata[31:0], 32'hDEADBEEF);
    check("t2_rd1", rdata[63:32], 32'hDEADBEEF);
    cyc();

    wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(0, 3);
    cyc(); idle();
    @(negedge clk);
    check("t3_prio", rdata[31:0], 32'h22);
    cyc();

    wr(0, 9, 32'h5A); rd(0, 9); rd(1, 9);
    @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
    check("t4_same", rdata[31:0], 32'h5A);
`else
    check("t4_same", rdata[31:0], 32'd90);
`endif
    cyc(); idle();
    @(negedge clk);
    check("t4_next", rdata[31:0], 32'h5A);
    cyc();

    wr(1, 0, 32'hFFFFFFFF); rd(0, 0);
    @(negedge clk);
    check("zero_same", rdata[31:0], 32'd0);
    cyc(); idle();
    @(negedge clk);
    check("zero_next", rdata[31:0], 32'd0);
    cyc();

    for (int i = 0; i < 8; i++) begin
      wr(0, i * 3 + 1, 32'h01010101 * 32'(i + 1));
      wr(1, 31 - i, 32'hA5000000 + 32'(i));
      rd(0, i * 3 + 1); rd(1, 31 - ((i + 7) % 8));
      cyc();
    end
    idle();
    rd(0, 31); rd(1, 4);
    @(negedge clk);
    check("mix_reg31", rdata[31:0], 32'hA5000000);
    check("mix_reg4", rdata[63:32], 32'h02020202);
    cyc();

    rd(0, 7); rd(1, 7);
    wr(0, 7, 32'h1234); clr = 1'b1;
    cyc(); idle();
    wait_ready("t5", 1'b1);
    check("t5_reg7", rdata[31:0], 32'd70);
    cyc();

    clr = 1'b1; cyc(); clr = 1'b0;
    repeat (5) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    wait_ready("clr_init", 1'b0);
    cyc();

    wr(0, 9, 32'h77); cyc(); idle();
    reset = 1'b1; cyc(); reset = 1'b0;
    repeat (12) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    rd(0, 7); rd(1, 9);
    wait_ready("t6", 1'b0);
    check("t6_reg7", rdata[31:0], 32'd70);
    check("t6_reg9", rdata[63:32], 32'd90);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
